regfile_uart_dump: RTL and testbench

- Debug reader for the pipeline's 32x32 register file.
- On a start pulse, walks addresses 0..NUM_REGS-1 through one register-file read port and serialises each 32-bit word over UART TX (8N1).
- Sits beside the register file and drives the board TX pin, or a TX mux shared with the UART configuration path.

---
 rtl/regfile_uart_dump_pkg.sv | 29 ++
 rtl/regfile_uart_dump_uart_tx_byte.sv | 120 ++++++++++++
 rtl/regfile_uart_dump.sv | 143 ++++++++++++++
 tb/tb_regfile_uart_dump.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_uart_dump_pkg.sv
// -----------------------------------------------------------------------------
// regfile_uart_dump_pkg
// Shared definitions for the register-file UART dump block:
//   - FSM state encodings (plain 3-bit constants, shared by top and byte TX)
//   - UART framing constants and word geometry
//   - word_byte(): little-endian byte select from a 32-bit word
// -----------------------------------------------------------------------------
package regfile_uart_dump_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop
  localparam int BYTES_PER_WORD  = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_STOP  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Byte idx of word, idx 0 = bits [7:0] (first on the wire).
  function automatic logic [7:0] word_byte(input logic [31:0] word,
                                           input logic [1:0]  idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/regfile_uart_dump_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 UART transmitter for one byte at a time, with back-to-back chaining.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request to send data; accepted while ready is high
//   data   in   byte to send, captured on acceptance
//   tx     out  registered serial line, idle high
//   busy   out  a frame is in progress (FSM not idle)
//   ready  out  a new byte can be accepted this cycle: idle, or the final
//               cycle of a stop bit (allows gapless consecutive frames)
// -----------------------------------------------------------------------------
module uart_tx_byte
  import regfile_uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       ready
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q,  baud_d;
  logic [2:0]        bit_q,   bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q,    tx_d;
  logic              bit_tick;

  assign bit_tick = (baud_q == BAUD_LAST);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    // Baud counter free-runs while a frame is active and wraps every bit.
    if (state_q != ST_IDLE) begin
      baud_d = bit_tick ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_START;
          shift_d = data;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_q == BIT_LAST) state_d = ST_STOP;
          else                   bit_d   = bit_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (start) begin
            state_d = ST_START;
            shift_d = data;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line level is registered from the current state, so the wire lags
  // the FSM by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[bit_q];
      default:  tx_d = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx    = tx_q;
  assign busy  = (state_q != ST_IDLE);
  assign ready = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_tick);

endmodule

// File: rtl/regfile_uart_dump.sv
// -----------------------------------------------------------------------------
// regfile_uart_dump
// Debug reader: on dump_start, reads registers 0..NUM_REGS-1 through one
// register-file read port and sends each 32-bit word little-endian over
// UART 8N1 (four back-to-back frames per word, one idle cycle between words).
// Ports:
//   clk_o       in   system clock, rising edge
//   rst         in   synchronous active-high reset; abandons a dump silently
//   dump_start  in   single-cycle dump request, honoured only when idle
//   rd_addr     out  register-file read address (current register index)
//   rd_data     in   combinational read data for rd_addr
//   tx          out  UART serial line, registered, idle high
//   busy        out  high from dump acceptance until done
//   done        out  one-cycle pulse as the final stop bit ends
// -----------------------------------------------------------------------------
module regfile_uart_dump
  import regfile_uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5
) (
  input  logic              clk_o,
  input  logic              rst,
  input  logic              dump_start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] REG_LAST  = ADDR_W'(NUM_REGS - 1);
  localparam logic [1:0]        BYTE_LAST = 2'(BYTES_PER_WORD - 1);

  // The top only sequences words and bytes; the START/STOP phases live in
  // uart_tx_byte, and the top spends a whole word's four frames in ST_DATA.
  state_t             state_q,    state_d;
  logic [ADDR_W-1:0]  reg_idx_q,  reg_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [31:0]        word_q,     word_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;

  logic               ub_start;
  logic [7:0]         ub_data;
  logic               ub_busy;
  logic               ub_ready;
  logic               frame_end;

  // Final cycle of a stop bit: the only point where the next byte may chain.
  assign frame_end = ub_busy && ub_ready;

  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    ub_start   = 1'b0;
    ub_data    = word_byte(word_q, byte_idx_q + 2'd1);

    case (state_q)
      ST_IDLE: begin
        if (dump_start) begin
          state_d   = ST_FETCH;
          reg_idx_d = '0;
        end
      end
      // Capture the word and launch byte 0 straight from the read port, so
      // the word costs one fetch cycle plus exactly four frames.
      ST_FETCH: begin
        word_d     = rd_data;
        byte_idx_d = '0;
        ub_start   = 1'b1;
        ub_data    = rd_data[7:0];
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        if (frame_end) begin
          if (byte_idx_q != BYTE_LAST) begin
            byte_idx_d = byte_idx_q + 2'd1;
            ub_start   = 1'b1;
          end else if (reg_idx_q != REG_LAST) begin
            reg_idx_d = reg_idx_q + 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        reg_idx_d = '0;
      end
      default: begin
        state_d   = ST_IDLE;
        reg_idx_d = '0;
      end
    endcase

    // Registered from the DONE state so done and the busy drop land on the
    // same edge as the end of the last stop bit on the (lagging) tx line.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  // NOTE: word_q is an ordinary data register with no consumer until FETCH
  // loads it, but it is cleared with the rest for deterministic reset state.
  always_ff @(posedge clk_o) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk_o),
    .rst  (rst),
    .start(ub_start),
    .data (ub_data),
    .tx   (tx),
    .busy (ub_busy),
    .ready(ub_ready)
  );

  assign rd_addr = reg_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_regfile_uart_dump.sv
// -----------------------------------------------------------------------------
// tb_regfile_uart_dump
// Two instances with CLKS_PER_BIT=4: a 32-register dump (A) and a 4-register
// dump (B). A UART decoder checks every bit of every frame on the selected
// tx line and pops the expected byte from a scoreboard filled at stimulus time.
// -----------------------------------------------------------------------------
module tb_regfile_uart_dump;

  localparam int CPB      = 4;
  localparam int NREG_A   = 32;
  localparam int NREG_B   = 4;
  localparam int WORD_CYC = 1 + 40 * CPB;  // 161

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;

  logic [4:0]  rd_addr_a;
  logic [1:0]  rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        tx_a, busy_a, done_a;
  logic        tx_b, busy_b, done_b;

  logic [31:0] regs_a [NREG_A];
  logic [31:0] regs_b [NREG_B];

  assign rd_data_a = regs_a[rd_addr_a];
  assign rd_data_b = regs_b[rd_addr_b];

  always #5 clk = ~clk;

  regfile_uart_dump #(.CLKS_PER_BIT(CPB), .NUM_REGS(NREG_A), .ADDR_W(5)) dut_a (
    .clk_o(clk), .rst(rst), .dump_start(start_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  regfile_uart_dump #(.CLKS_PER_BIT(CPB), .NUM_REGS(NREG_B), .ADDR_W(2)) dut_b (
    .clk_o(clk), .rst(rst), .dump_start(start_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // ---------------- UART decoder / scoreboard consumer ----------------------
  logic       sel_b = 1'b0;
  logic       mon_tx;
  logic       mon_active = 1'b0;
  logic       mon_bit;
  logic [7:0] mon_byte;
  logic [7:0] exp_b;
  int         mon_cnt = 0;
  int         mon_pos, mon_sub;
  int         mon_bytes = 0;

  assign mon_tx = sel_b ? tx_b : tx_a;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && mon_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
      if (mon_active) begin
        mon_pos = mon_cnt / CPB;
        mon_sub = mon_cnt % CPB;
        if (mon_pos == 0) begin
          check("start_bit", mon_tx, 1'b0);
        end else if (mon_pos <= 8) begin
          if (mon_sub == 0) begin
            mon_bit               = mon_tx;
            mon_byte[mon_pos - 1] = mon_tx;
          end else begin
            check("data_bit_hold", mon_tx, mon_bit);
          end
        end else begin
          check("stop_bit", mon_tx, 1'b1);
        end
        if (mon_cnt == 10 * CPB - 1) begin
          exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check("rx_byte", mon_byte, exp_b);
          mon_bytes++;
          mon_active = 1'b0;
        end else begin
          mon_cnt++;
        end
      end
    end
  end

  int done_cnt_a = 0;
  int done_cnt_b = 0;
  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a++;
    if (done_b === 1'b1) done_cnt_b++;
  end

  // ---------------- directed sequence ---------------------------------------
  int cyc, wt, prev_addr, addr_steps, r5_seen, r1_seen;
  bit pulsed, written;

  initial begin
    for (int i = 0; i < NREG_A; i++) regs_a[i] = '0;
    regs_a[1] = 32'h1234_5678;
    regs_b[0] = '0;
    regs_b[1] = 32'hCAFE_F00D;
    regs_b[2] = 32'h1111_1111;
    regs_b[3] = 32'h0BAD_C0DE;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_rd_addr", rd_addr_a, 0);
    check("rst_tx_b", tx_b, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Dump 1: full 32-register dump, extra dump_start in the middle of r5
    for (int r = 0; r < NREG_A; r++) push_word(regs_a[r]);
    mon_bytes = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    check("busy_rise", busy_a, 1'b1);
    check("first_rd_addr", rd_addr_a, 0);
    check("tx_idle_edge0", tx_a, 1'b1);
    @(negedge clk); cyc++;
    check("tx_high_edge1", tx_a, 1'b1);
    @(negedge clk); cyc++;
    check("tx_low_edge2", tx_a, 1'b0);
    prev_addr = 0; addr_steps = 0; r5_seen = 0; pulsed = 0;
    while (done_a !== 1'b1 && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (start_a) start_a = 1'b0;
      if (busy_a === 1'b1 && int'(rd_addr_a) != prev_addr) begin
        check("rd_addr_step", rd_addr_a, prev_addr + 1);
        prev_addr = int'(rd_addr_a);
        addr_steps++;
      end
      if (rd_addr_a == 5) r5_seen++;
      if (r5_seen == 80 && !pulsed) begin
        start_a = 1'b1;
        pulsed  = 1;
      end
    end
    check("done_latency", cyc, 1 + NREG_A * WORD_CYC);
    check("busy_fall_with_done", busy_a, 1'b0);
    check("rd_addr_steps", addr_steps, NREG_A - 1);
    check("rd_addr_back_to_0", rd_addr_a, 0);
    @(negedge clk);
    check("done_one_cycle", done_a, 1'b0);
    repeat (50) @(negedge clk);
    check("no_restart", busy_a, 1'b0);
    check("done_count_1", done_cnt_a, 1);
    check("sb_empty_1", exp_q.size(), 0);
    check("bytes_seen_1", mon_bytes, 4 * NREG_A);

    // Dump 2: reset during the data bits of r3 byte 2
    exp_q.delete();
    for (int r = 0; r < NREG_A; r++) push_word(regs_a[r]);
    mon_bytes = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wt = 0;
    while (!(mon_bytes == 14 && mon_active && mon_cnt >= 12 && mon_cnt <= 28)
           && wt < 10000) begin
      @(negedge clk); wt++;
    end
    check("reached_r3", rd_addr_a, 3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx_a, 1'b1);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_rd_addr", rd_addr_a, 0);
    check("midrst_done", done_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt_a, 1);
    check("midrst_idle", busy_a, 1'b0);

    // Dump 3: fresh start after the abandoned dump begins again at r0
    for (int r = 0; r < NREG_A; r++) push_word(regs_a[r]);
    mon_bytes = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    check("restart_busy", busy_a, 1'b1);
    check("restart_rd_addr", rd_addr_a, 0);
    while (done_a !== 1'b1 && cyc < 20000) begin
      @(negedge clk); cyc++;
    end
    check("restart_done_latency", cyc, 1 + NREG_A * WORD_CYC);
    repeat (10) @(negedge clk);
    check("done_count_2", done_cnt_a, 2);
    check("sb_empty_2", exp_q.size(), 0);
    check("bytes_seen_2", mon_bytes, 4 * NREG_A);

    // Dump B: NUM_REGS=4, r2 rewritten while r1 is on the wire
    sel_b = 1'b1;
    exp_q.delete();
    push_word(regs_b[0]);
    push_word(regs_b[1]);
    push_word(32'hDEAD_BEEF);
    push_word(regs_b[3]);
    mon_bytes = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0; r1_seen = 0; written = 0;
    while (done_b !== 1'b1 && cyc < 5000) begin
      @(negedge clk); cyc++;
      if (rd_addr_b == 2'd1) r1_seen++;
      if (r1_seen == 10 && !written) begin
        regs_b[2] = 32'hDEAD_BEEF;
        written   = 1;
      end
    end
    check("b_done_latency", cyc, 1 + NREG_B * WORD_CYC);
    check("b_busy_fall", busy_b, 1'b0);
    repeat (10) @(negedge clk);
    check("b_done_count", done_cnt_b, 1);
    check("b_sb_empty", exp_q.size(), 0);
    check("b_bytes_seen", mon_bytes, 4 * NREG_B);
    check("a_untouched", done_cnt_a, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
